// File: rtl/loop_controller_pkg.sv
// ---------------------------------------------------------------------------
// loop_controller_pkg
//   Shared definitions for the loop controller and the blocks around it
//   (counter bench, top-level datapath).
//   - DEF_N   : default width of the controlled up-counter
//   - DEF_P_W : default width of the pass-count / pass-index fields
//   - state_e : controller state encoding, fixed so other blocks can decode it
// ---------------------------------------------------------------------------
package loop_controller_pkg;

    localparam int DEF_N   = 6;
    localparam int DEF_P_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/loop_controller.sv
// ---------------------------------------------------------------------------
// loop_controller
//   Control FSM sitting directly upstream of a loadable up-counter. Each pass
//   loads the counter with a start value and lets it count to all-ones; the
//   whole sequence repeats for a programmable number of passes.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous, active-high reset
//   start       in   run request, sampled only in IDLE
//   init_val    in   [N]   counter start value, latched on accepted start
//   num_passes  in   [P_W] number of passes, latched on accepted start
//   stall       in   freezes counting while in COUNT
//   co          in   counter carry-out (en AND all-ones), combinational
//   cnt_en      out  counter enable
//   cnt_ld      out  counter load strobe
//   cnt_init    out  [N]   counter load value (latched init_val)
//   busy        out  high in LOAD and COUNT
//   pass_done   out  one-cycle pulse in the cycle after each pass completes
//   pass_idx    out  [P_W] 0-based index of the current pass
//   done        out  one-cycle pulse on completion of the whole run
// ---------------------------------------------------------------------------
module loop_controller
    import loop_controller_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int P_W = DEF_P_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   init_val,
    input  logic [P_W-1:0] num_passes,
    input  logic           stall,
    input  logic           co,
    output logic           cnt_en,
    output logic           cnt_ld,
    output logic [N-1:0]   cnt_init,
    output logic           busy,
    output logic           pass_done,
    output logic [P_W-1:0] pass_idx,
    output logic           done
);

    state_e         state_q,     state_d;
    logic [N-1:0]   init_q,      init_d;
    logic [P_W-1:0] passes_q,    passes_d;
    logic [P_W-1:0] idx_q,       idx_d;
    logic           pass_done_q, pass_done_d;
    logic           last_pass;

    // Index arithmetic is modulo 2^P_W; the equality compare is why the
    // largest usable pass count is 2^P_W-1.
    assign last_pass = (idx_q == P_W'(passes_q - P_W'(1)));

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        init_d      = init_q;
        passes_d    = passes_q;
        idx_d       = idx_q;
        pass_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_passes != '0) begin
                        init_d   = init_val;
                        passes_d = num_passes;
                        idx_d    = '0;
                        state_d  = LOAD;
                    end else begin
                        // Nothing to count: report completion without a load.
                        state_d = DONE;
                    end
                end
            end
            LOAD: state_d = COUNT;
            COUNT: begin
                // co only means anything here; it is already gated by cnt_en,
                // so a stalled all-ones cycle cannot end the pass.
                if (co) begin
                    pass_done_d = 1'b1;
                    if (last_pass) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + P_W'(1);
                        state_d = LOAD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q     <= IDLE;
            init_q      <= '0;
            passes_q    <= '0;
            idx_q       <= '0;
            pass_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            passes_q    <= passes_d;
            idx_q       <= idx_d;
            pass_done_q <= pass_done_d;
        end
    end

    // Moore decode of the registered state; only cnt_en also looks at stall
    // so a frozen cycle takes effect in the same cycle.
    assign cnt_ld    = (state_q == LOAD);
    assign cnt_en    = (state_q == COUNT) && !stall;
    assign busy      = (state_q == LOAD) || (state_q == COUNT);
    assign done      = (state_q == DONE);
    assign cnt_init  = init_q;
    assign pass_idx  = idx_q;
    assign pass_done = pass_done_q;

endmodule

// File: tb/tb_loop_controller.sv
// ---------------------------------------------------------------------------
// tb_loop_controller
//   Drives loop_controller together with a behavioural loadable up-counter
//   whose carry-out is fed back. Table-driven runs, hand-written multi-cycle
//   sequences, and randomized runs compared against a trace model.
// ---------------------------------------------------------------------------
module tb_loop_controller;
    import loop_controller_pkg::*;

    localparam int N   = DEF_N;
    localparam int P_W = DEF_P_W;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   init_val;
    logic [P_W-1:0] num_passes;
    logic           stall;
    logic           co;
    logic           cnt_en;
    logic           cnt_ld;
    logic [N-1:0]   cnt_init;
    logic           busy;
    logic           pass_done;
    logic [P_W-1:0] pass_idx;
    logic           done;

    int vec_cnt = 0;
    int err_cnt = 0;

    loop_controller #(.N(N), .P_W(P_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .init_val   (init_val),
        .num_passes (num_passes),
        .stall      (stall),
        .co         (co),
        .cnt_en     (cnt_en),
        .cnt_ld     (cnt_ld),
        .cnt_init   (cnt_init),
        .busy       (busy),
        .pass_done  (pass_done),
        .pass_idx   (pass_idx),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Loadable up-counter the controller drives.
    logic [N-1:0] cnt = '0;
    always @(posedge clk) begin
        if (cnt_ld)      cnt <= cnt_init;
        else if (cnt_en) cnt <= cnt + 1'b1;
    end
    assign co = cnt_en & (&cnt);

    typedef struct packed {
        logic           en;
        logic           ld;
        logic           busy;
        logic           pd;
        logic           done;
        logic           co;
        logic [P_W-1:0] idx;
        logic [N-1:0]   init;
    } obs_t;

    obs_t obs;

    typedef struct {
        logic [N-1:0] init;
        int           passes;
        int           done_cyc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, sample at the
    // falling edge, return just after the next rising edge.
    task automatic cyc(input logic st, input logic sl);
        start = st;
        stall = sl;
        @(negedge clk);
        obs.en   = cnt_en;
        obs.ld   = cnt_ld;
        obs.busy = busy;
        obs.pd   = pass_done;
        obs.done = done;
        obs.co   = co;
        obs.idx  = pass_idx;
        obs.init = cnt_init;
        @(posedge clk);
        #1;
    endtask

    // Start a run in cycle 0 and tally outputs until done (bounded).
    task automatic run_entry(input logic [N-1:0] v, input int np, input int exp_done, input string tag);
        int dc, ld_n, pd_n, co_n, en_n, busy_n, len;
        logic [P_W-1:0] li;
        dc = -1; ld_n = 0; pd_n = 0; co_n = 0; en_n = 0; busy_n = 0; li = '0;
        init_val   = v;
        num_passes = P_W'(np);
        cyc(1'b1, 1'b0);
        for (int c = 1; c <= 1000 && dc < 0; c++) begin
            cyc(1'b0, 1'b0);
            ld_n   += int'(obs.ld);
            pd_n   += int'(obs.pd);
            co_n   += int'(obs.co);
            en_n   += int'(obs.en);
            busy_n += int'(obs.busy);
            if (obs.done) begin
                dc = c;
                li = obs.idx;
            end
        end
        cyc(1'b0, 1'b0);
        len = (1 << N) - int'(v);
        check({tag, " done_cycle"}, dc, exp_done);
        check({tag, " loads"}, ld_n, np);
        check({tag, " pass_done_pulses"}, pd_n, np);
        check({tag, " carries"}, co_n, np);
        check({tag, " en_cycles"}, en_n, np * len);
        check({tag, " busy_cycles"}, busy_n, np * (len + 1));
        if (np > 0) check({tag, " final_idx"}, li, np - 1);
    endtask

    // Exact cycle positions of ld/co/pass_done/done for init 60, 2 passes;
    // optionally pokes a second start with different settings mid-run.
    task automatic normal_run(input bit poke, input string tag);
        logic [15:0] ld_m, co_m, pd_m, dn_m;
        logic [P_W-1:0] idx3, idx8;
        logic [N-1:0] init9;
        ld_m = '0; co_m = '0; pd_m = '0; dn_m = '0; idx3 = '0; idx8 = '0; init9 = '0;
        init_val   = 6'd60;
        num_passes = 3'd2;
        cyc(1'b1, 1'b0);
        for (int c = 1; c <= 13; c++) begin
            if (poke && c == 3) begin
                init_val   = 6'd10;
                num_passes = 3'd5;
                cyc(1'b1, 1'b0);
            end else begin
                cyc(1'b0, 1'b0);
            end
            ld_m[c] = obs.ld;
            co_m[c] = obs.co;
            pd_m[c] = obs.pd;
            dn_m[c] = obs.done;
            if (c == 3) idx3 = obs.idx;
            if (c == 8) idx8 = obs.idx;
            if (c == 9) init9 = obs.init;
        end
        check({tag, " ld_cycles"}, ld_m, 16'h0042);
        check({tag, " co_cycles"}, co_m, 16'h0420);
        check({tag, " pass_done_cycles"}, pd_m, 16'h0840);
        check({tag, " done_cycles"}, dn_m, 16'h0800);
        check({tag, " idx_pass0"}, idx3, 0);
        check({tag, " idx_pass1"}, idx8, 1);
        check({tag, " cnt_init"}, init9, 60);
    endtask

    // Randomized run: the expected per-cycle trace is built from the pass
    // rules (one load cycle, then 2^N-v enabled count cycles, stalled cycles
    // inserted where stall is high, pass_done one cycle after each carry).
    task automatic rand_run(input logic [N-1:0] v, input int np, input int run_no);
        obs_t q[$];
        obs_t r;
        bit   sp[];
        bit   pdn;
        int   k, rem;
        sp = new[4000];
        foreach (sp[i]) sp[i] = ($urandom_range(0, 3) == 0);
        pdn = 1'b0;
        k   = 1;
        for (int p = 0; p < np; p++) begin
            r = '0; r.ld = 1'b1; r.busy = 1'b1; r.idx = P_W'(p); r.init = v; r.pd = pdn;
            pdn = 1'b0;
            q.push_back(r);
            k++;
            rem = (1 << N) - int'(v);
            while (rem > 0) begin
                r = '0; r.busy = 1'b1; r.idx = P_W'(p); r.init = v; r.pd = pdn;
                r.en = (k < 4000) ? !sp[k] : 1'b1;
                r.co = r.en && (rem == 1);
                pdn  = r.co;
                if (r.en) rem--;
                q.push_back(r);
                k++;
            end
        end
        r = '0; r.done = 1'b1; r.idx = P_W'(np - 1); r.init = v; r.pd = pdn;
        q.push_back(r);
        r = '0; r.idx = P_W'(np - 1); r.init = v;
        q.push_back(r);

        init_val   = v;
        num_passes = P_W'(np);
        cyc(1'b1, 1'b0);
        for (int i = 0; i < q.size(); i++) begin
            logic st;
            // Spurious starts and changing settings must be ignored until IDLE.
            st         = (i < q.size() - 1) && ($urandom_range(0, 7) == 0);
            init_val   = N'($urandom);
            num_passes = P_W'($urandom);
            cyc(st, (i + 1 < 4000) ? sp[i + 1] : 1'b0);
            check($sformatf("rand run%0d cyc%0d", run_no, i + 1), 32'(obs), 32'(q[i]));
        end
    endtask

    initial begin
        vec_t tbl[8];
        int   dn_n, bz_n;
        logic [15:0] co_m, dn_m, en_m;

        tbl[0] = '{init: 6'd60, passes: 2, done_cyc: 11};
        tbl[1] = '{init: 6'd0,  passes: 0, done_cyc: 1};
        tbl[2] = '{init: 6'd63, passes: 3, done_cyc: 7};
        tbl[3] = '{init: 6'd62, passes: 1, done_cyc: 4};
        tbl[4] = '{init: 6'd0,  passes: 1, done_cyc: 66};
        tbl[5] = '{init: 6'd32, passes: 7, done_cyc: 232};
        tbl[6] = '{init: 6'd63, passes: 7, done_cyc: 15};
        tbl[7] = '{init: 6'd10, passes: 2, done_cyc: 111};

        rst = 1'b1; start = 1'b0; stall = 1'b0; init_val = '0; num_passes = '0;
        @(posedge clk); #1;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("reset_outputs", 32'(obs), 0);
        rst = 1'b0;
        cyc(1'b0, 1'b0);

        for (int i = 0; i < 8; i++)
            run_entry(tbl[i].init, tbl[i].passes, tbl[i].done_cyc, $sformatf("tbl%0d", i));

        normal_run(1'b0, "normal");
        normal_run(1'b1, "start_busy");

        // Stall for three cycles while the counter sits at all-ones.
        co_m = '0; dn_m = '0; en_m = '0;
        init_val = 6'd62; num_passes = 3'd1;
        cyc(1'b1, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            cyc(1'b0, (c >= 3 && c <= 5));
            co_m[c] = obs.co;
            dn_m[c] = obs.done;
            en_m[c] = obs.en;
        end
        check("stall co_cycles", co_m, 16'h0040);
        check("stall done_cycles", dn_m, 16'h0080);
        check("stall en_cycles", en_m, 16'h0044);

        // Reset in the 20th COUNT cycle of a long run.
        init_val = 6'd0; num_passes = 3'd4;
        cyc(1'b1, 1'b0);
        for (int c = 1; c <= 20; c++) cyc(1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        check("midrst busy_before", {obs.busy, obs.en}, 2'b11);
        rst = 1'b0;
        cyc(1'b0, 1'b0);
        check("midrst outputs", 32'(obs), 0);
        dn_n = 0; bz_n = 0;
        for (int c = 0; c < 5; c++) begin
            cyc(1'b0, 1'b0);
            dn_n += int'(obs.done);
            bz_n += int'(obs.busy);
        end
        check("midrst no_done", dn_n, 0);
        check("midrst idle", bz_n, 0);
        run_entry(6'd60, 1, 6, "after_rst");

        for (int r = 0; r < 16; r++) begin
            logic [N-1:0] v;
            v = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 63)) : N'($urandom_range(50, 63));
            rand_run(v, $urandom_range(1, 7), r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
